load_store_unit: RTL
====================

# load_store_unit

Initiator-side memory access unit sitting between the CPU datapath and the word-organised data memory. It accepts byte/halfword/word load and store requests on a valid/ready handshake and converts byte addresses to word indices. It performs lane extraction with sign or zero extension for loads, and read-modify-write for sub-word stores, because the data memory only writes whole 32-bit words. It drives the data memory's `mem_read`/`mem_write`/`address`/`write_data` port and consumes its combinational `read_data`.

## Interface
- `WORD_ADDR_BITS`, default 8: number of word-index bits the memory decodes; upper bits of `mem_address` are driven 0.
- `clk`  in  1  rising-edge clock, the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  unit can accept a request this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_error`  out  1  misaligned request, qualified by `resp_valid`.
- `mem_read`  out  1  to data memory read enable.
- `mem_write`  out  1  to data memory write enable (committed at `clk` rise).
- `mem_address`  out  32  word index = `{0, addr[WORD_ADDR_BITS+1:2]}`.
- `mem_write_data`  out  32  full word to write.
- `mem_read_data`  in  32  combinational read data, valid in the same cycle as `mem_read`.

## Operation
- States: IDLE, LOAD, RMW_RD, STORE, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch write, size, unsigned, addr, wdata.
  - Misaligned requests go to RESP with error and no memory access. A halfword is misaligned when addr[0]=1; a word when addr[1:0]≠0.
  - Load goes to LOAD. Word store goes to STORE. Byte/half store goes to RMW_RD.
- LOAD: `mem_read`=1. Capture `mem_read_data` at the clock edge. Select lane by latched addr[1:0], little-endian: byte k = bits [8k+7:8k], half at addr[1] = bits [16·addr[1]+15:16·addr[1]]. Extend per `req_unsigned`. Go to RESP.
- RMW_RD: `mem_read`=1. Capture the word into the merge register. Go to STORE.
- STORE: `mem_write`=1. `mem_write_data` = latched wdata (word), or the merge word with only the addressed byte/half lane replaced. Go to RESP.
- RESP: `resp_valid`=1 with `resp_rdata`/`resp_error`. Go to IDLE.
- `mem_*` and `resp_*` outputs are decoded from the state and latched registers only. There is no combinational path from `req_*` to any output except `req_ready`.
- Outside LOAD/RMW_RD/STORE, `mem_read`=`mem_write`=0 and `mem_address`/`mem_write_data` are 0.
- `mem_read` and `mem_write` are never both 1.

## Timing
- Request accepted at edge E (IDLE, `req_valid`=1).
- Load: LOAD in cycle E+1, `resp_valid` in cycle E+2.
- Word store: write commits at edge E+2, `resp_valid` in cycle E+2.
- Sub-word store: read in cycle E+1, write commits at edge E+3, `resp_valid` in cycle E+3.
- Misaligned: `resp_valid`+`resp_error` in cycle E+1; no `mem_read`/`mem_write` pulse.
- The cycle after RESP is IDLE. A new request is accepted at the edge ending that IDLE cycle, so the minimum initiation interval is load 3 / word store 3 / sub-word store 4 cycles.
- `req_valid` while `req_ready`=0 is ignored and not queued; the CPU must hold it.
- Reset: when `rst_n`=0 at a rising edge, state becomes IDLE and all latched registers clear to 0.
  - While `rst_n`=0, `req_ready`, `mem_read`, `mem_write` and `resp_valid` are forced to 0.
  - A reset asserted in STORE suppresses that write, so memory is left unchanged.
  - After reset deasserts, the first cycle is IDLE with `req_ready`=1.
- Reset values: `req_ready` 0 during reset then 1; all other outputs 0.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `req_valid`=1 -> all outputs 0, no memory access. First cycle after release has `req_ready`=1.
- Word store `addr` 0x100, data 0xDEADBEEF -> `mem_write`=1, `mem_address`=0x40 in cycle E+1. Then load word 0x100 -> `resp_rdata`=0xDEADBEEF in cycle E+2.
- Byte store 0xA5 to 0x101 over 0xDEADBEEF -> RMW read, then write 0xDEADA5EF.
  - `lb` 0x101 -> 0xFFFFFFA5.
  - `lbu` 0x101 -> 0x000000A5.
- Halfword store 0x8234 to 0x102 -> word 0x8234A5EF.
  - `lh` 0x102 -> 0xFFFF8234.
  - `lhu` -> 0x00008234.
- Misaligned `lh` 0x103 and `lw` 0x102 -> `resp_error`=1 and `resp_rdata`=0 in cycle E+1. No `mem_read`/`mem_write` pulse.
- Reset asserted in STORE of a word store to 0x104 -> `mem_write` forced 0 and the word at 0x104 is unchanged. Also check: `req_valid` held through a busy load is accepted exactly once, in the IDLE cycle following RESP.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bundles the CPU request/response handshake and the data-memory port of the load/store unit.
// slave is the unit's view; master is the environment (CPU plus memory) view.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_read, mem_write, mem_address, mem_write_data
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_read, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a word-only data memory; sub-word stores
// are done as read-modify-write.
module load_store_unit #(
    parameter int unsigned WORD_ADDR_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus
);
    localparam int unsigned AW = WORD_ADDR_BITS + 2;

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, RESP} state_t;

    state_t          state_q, state_d;
    logic            write_q, unsigned_q, error_q;
    logic [1:0]      size_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q, merge_q, rdata_q;

    logic            accept, misaligned;
    logic            ready, rd_en, wr_en, resp_en;
    logic [4:0]      lane_shift;
    logic [31:0]     load_shifted, load_ext, lane_mask, store_word;
    logic            unused_addr_hi;

    assign unused_addr_hi = ^bus.req_addr[31:AW];
    assign accept         = (state_q == IDLE) && bus.req_valid;
    assign misaligned     = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                            (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Request latch, load result and RMW merge word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            error_q    <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            rdata_q    <= '0;
        end else begin
            if (accept) begin
                write_q    <= bus.req_write;
                unsigned_q <= bus.req_unsigned;
                error_q    <= misaligned;
                size_q     <= bus.req_size;
                addr_q     <= bus.req_addr[AW-1:0];
                wdata_q    <= bus.req_wdata;
                rdata_q    <= '0;
            end
            if (state_q == LOAD)   rdata_q <= load_ext;
            if (state_q == RMW_RD) merge_q <= bus.mem_read_data;
        end
    end

    // Lane extraction/extension for loads and lane merge for stores
    always_comb begin
        lane_shift   = {addr_q[1:0], 3'b000};
        load_shifted = bus.mem_read_data >> lane_shift;
        unique case (size_q)
            2'b00:   load_ext = unsigned_q ? {24'b0, load_shifted[7:0]}
                                           : {{24{load_shifted[7]}}, load_shifted[7:0]};
            2'b01:   load_ext = unsigned_q ? {16'b0, load_shifted[15:0]}
                                           : {{16{load_shifted[15]}}, load_shifted[15:0]};
            default: load_ext = bus.mem_read_data;
        endcase
        lane_mask  = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_shift;
        store_word = size_q[1] ? wdata_q
                               : ((merge_q & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask));
    end

    // Next-state and control decode
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        resp_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.req_valid) begin
                    if (misaligned)           state_d = RESP;
                    else if (!bus.req_write)  state_d = LOAD;
                    else if (bus.req_size[1]) state_d = STORE;
                    else                      state_d = RMW_RD;
                end
            end
            LOAD: begin
                rd_en   = 1'b1;
                state_d = RESP;
            end
            RMW_RD: begin
                rd_en   = 1'b1;
                state_d = STORE;
            end
            STORE: begin
                wr_en   = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                resp_en = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset low forces every output quiet, including a write already in STORE
    assign bus.req_ready      = rst_n && ready;
    assign bus.mem_read       = rst_n && rd_en;
    assign bus.mem_write      = rst_n && wr_en;
    assign bus.mem_address    = (rst_n && (rd_en || wr_en)) ? 32'(addr_q[AW-1:2]) : 32'h0;
    assign bus.mem_write_data = (rst_n && wr_en) ? store_word : 32'h0;
    assign bus.resp_valid     = rst_n && resp_en;
    assign bus.resp_rdata     = (rst_n && resp_en) ? rdata_q : 32'h0;
    assign bus.resp_error     = rst_n && resp_en && error_q;
endmodule
